// File: rtl/batalha_rodadas.sv
// ---------------------------------------------------------------------------
// batalha_rodadas
//   Multi-round two-player code battle. Player 1 commits a hidden W-bit code,
//   which is mapped to a target (bit-reversed code XOR KEY). Player 2 then has
//   up to TRIES guesses per round to hit that target. Scores are kept over
//   ROUNDS rounds, and a winner is declared at the end of the game.
//
// Optional feature macro: BATALHA_DICA_EN
//   When defined, adds the 'dica' hint output (01 = last wrong guess was
//   below target, 10 = above). It stays high for one cycle after each wrong
//   guess.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   begin a new game (honoured in IDLE or OVER only)
//   p1_code     in   player 1 code            p1_valid  in  commit strobe
//   p2_code     in   player 2 guess           p2_valid  in  guess strobe
//   s1 / s2     out  one-cycle round-won pulse for player 1 / player 2
//   score1/2    out  per-player scores
//   round       out  rounds completed in the current game
//   tries_left  out  guesses remaining in the current round
//   busy        out  game in progress (COMMIT, GUESS, RESULT)
//   game_over   out  high in OVER
//   winner      out  in OVER: 01 p1, 10 p2, 11 tie; 00 otherwise
//   dica        out  (BATALHA_DICA_EN only) hint after a wrong guess
// ---------------------------------------------------------------------------
module batalha_rodadas #(
  parameter int             W      = 3,
  parameter int             ROUNDS = 5,
  parameter int             TRIES  = 3,
  parameter logic [W-1:0]   KEY    = 3'b101
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [W-1:0]                   p1_code,
  input  logic                           p1_valid,
  input  logic [W-1:0]                   p2_code,
  input  logic                           p2_valid,
  output logic                           s1,
  output logic                           s2,
  output logic [$clog2(ROUNDS+1)-1:0]    score1,
  output logic [$clog2(ROUNDS+1)-1:0]    score2,
  output logic [$clog2(ROUNDS+1)-1:0]    round,
  output logic [$clog2(TRIES+1)-1:0]     tries_left,
  output logic                           busy,
  output logic                           game_over,
  output logic [1:0]                     winner
`ifdef BATALHA_DICA_EN
  ,
  output logic [1:0]                     dica
`endif
);

  localparam int SW = $clog2(ROUNDS + 1);
  localparam int TW = $clog2(TRIES + 1);
  localparam logic [SW-1:0] ROUNDS_V = SW'(ROUNDS);
  localparam logic [TW-1:0] TRIES_V  = TW'(TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMMIT,
    S_GUESS,
    S_RESULT,
    S_OVER
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [W-1:0]  r_target;
  logic [TW-1:0] r_tries;
  logic [SW-1:0] r_score1;
  logic [SW-1:0] r_score2;
  logic [SW-1:0] r_round;
  logic          r_s1;
  logic          r_s2;
`ifdef BATALHA_DICA_EN
  logic [1:0]    r_dica;
`endif

  logic [W-1:0]  w_reversed;
  logic [W-1:0]  w_mapped;
  logic          w_uniform;
  logic          w_hit;
  logic          w_lastTry;
  logic          w_acceptCommit;
  logic          w_acceptGuess;
  logic          w_startGame;
  logic          w_p1Wins;
  logic          w_p2Wins;

  // Code-to-target mapping. Only the target is kept after the commit; the
  // raw code is never needed again once it has been mapped.
  always_comb begin
    w_reversed = '0;
    for (int i = 0; i < W; i++) begin
      w_reversed[i] = p1_code[W-1-i];
    end
    w_mapped  = w_reversed ^ KEY;
    w_uniform = (p1_code == '0) || (p1_code == '1);
  end

  assign w_hit          = (p2_code == r_target);
  assign w_lastTry      = (r_tries == TW'(1));
  assign w_acceptCommit = (r_state == S_COMMIT) && p1_valid;
  assign w_acceptGuess  = (r_state == S_GUESS) && p2_valid;
  assign w_startGame    = start && ((r_state == S_IDLE) || (r_state == S_OVER));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and decoded status outputs. A round is decided on the
  // edge that enters RESULT, so the winner flags are only raised on
  // transitions into RESULT.
  always_comb begin
    w_next    = r_state;
    w_p1Wins  = 1'b0;
    w_p2Wins  = 1'b0;
    busy      = 1'b0;
    game_over = 1'b0;
    winner    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        busy = 1'b1;
        if (w_acceptCommit) begin
          if (w_uniform) begin
            w_next   = S_RESULT;
            w_p1Wins = 1'b1;
          end else begin
            w_next = S_GUESS;
          end
        end
      end
      S_GUESS: begin
        busy = 1'b1;
        if (w_acceptGuess) begin
          if (w_hit) begin
            w_next   = S_RESULT;
            w_p2Wins = 1'b1;
          end else if (w_lastTry) begin
            w_next   = S_RESULT;
            w_p1Wins = 1'b1;
          end
        end
      end
      S_RESULT: begin
        busy   = 1'b1;
        w_next = (r_round == ROUNDS_V) ? S_OVER : S_COMMIT;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (r_score1 > r_score2)      winner = 2'b01;
        else if (r_score2 > r_score1) winner = 2'b10;
        else                          winner = 2'b11;
        if (start) w_next = S_COMMIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Scores and round move on the same edge that raises the s1/s2
  // pulse. The round counter cannot pass ROUNDS because the game leaves for
  // OVER as soon as it gets there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target <= '0;
      r_tries  <= '0;
      r_score1 <= '0;
      r_score2 <= '0;
      r_round  <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
`ifdef BATALHA_DICA_EN
      r_dica   <= 2'b00;
`endif
    end else begin
      r_s1 <= w_p1Wins;
      r_s2 <= w_p2Wins;
`ifdef BATALHA_DICA_EN
      r_dica <= 2'b00;
`endif
      if (w_startGame) begin
        r_score1 <= '0;
        r_score2 <= '0;
        r_round  <= '0;
      end
      if (w_acceptCommit) begin
        r_target <= w_mapped;
        r_tries  <= TRIES_V;
      end
      if (w_acceptGuess && !w_hit) begin
        r_tries <= r_tries - TW'(1);
`ifdef BATALHA_DICA_EN
        r_dica  <= (p2_code < r_target) ? 2'b01 : 2'b10;
`endif
      end
      if (w_p1Wins) begin
        r_score1 <= r_score1 + SW'(1);
        r_round  <= r_round + SW'(1);
      end
      if (w_p2Wins) begin
        r_score2 <= r_score2 + SW'(1);
        r_round  <= r_round + SW'(1);
      end
    end
  end

  assign s1         = r_s1;
  assign s2         = r_s2;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign round      = r_round;
  assign tries_left = r_tries;
`ifdef BATALHA_DICA_EN
  assign dica       = r_dica;
`endif

endmodule

// File: tb/tb_batalha_rodadas.sv
// ---------------------------------------------------------------------------
// tb_batalha_rodadas
//   Self-checking bench for batalha_rodadas (default parameters). A game-level
//   reference model predicts every output after each clock edge. A directed
//   sequence walks through the documented scenarios, and then a long run of
//   random strobes, codes, starts and occasional resets follows.
//   Honours BATALHA_DICA_EN when defined.
// ---------------------------------------------------------------------------
module tb_batalha_rodadas;

  localparam int W      = 3;
  localparam int ROUNDS = 5;
  localparam int TRIES  = 3;
  localparam int KEY    = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] p1_code;
  logic       p1_valid;
  logic [2:0] p2_code;
  logic       p2_valid;
  logic       s1;
  logic       s2;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [2:0] round;
  logic [1:0] tries_left;
  logic       busy;
  logic       game_over;
  logic [1:0] winner;
`ifdef BATALHA_DICA_EN
  logic [1:0] dica;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: game phase held as a readable name, numbers as ints.
  string mPhase = "idle";
  int mScore1 = 0, mScore2 = 0, mRound = 0, mTries = 0, mTarget = 0;
  int mS1 = 0, mS2 = 0, mDica = 0;

  batalha_rodadas #(.W(W), .ROUNDS(ROUNDS), .TRIES(TRIES), .KEY(3'b101)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .p1_code    (p1_code),
    .p1_valid   (p1_valid),
    .p2_code    (p2_code),
    .p2_valid   (p2_valid),
    .s1         (s1),
    .s2         (s2),
    .score1     (score1),
    .score2     (score2),
    .round      (round),
    .tries_left (tries_left),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner)
`ifdef BATALHA_DICA_EN
    ,
    .dica       (dica)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int mapTarget(input int code);
    int rev = 0;
    for (int i = 0; i < W; i++) begin
      if (((code >> i) & 1) == 1) rev += (1 << (W - 1 - i));
    end
    return rev ^ KEY;
  endfunction

  function automatic void winRound(input int who);
    if (who == 1) begin
      mScore1++;
      mS1 = 1;
    end else begin
      mScore2++;
      mS2 = 1;
    end
    mRound++;
    mPhase = "result";
  endfunction

  // Predicts the effect of one clock edge with the given inputs.
  function automatic void modelStep(input int rn, input int st, input int p1v,
                                    input int p1c, input int p2v, input int p2c);
    mS1 = 0;
    mS2 = 0;
    mDica = 0;
    if (rn == 0) begin
      mPhase = "idle";
      mScore1 = 0; mScore2 = 0; mRound = 0; mTries = 0; mTarget = 0;
      return;
    end
    if (mPhase == "idle" || mPhase == "over") begin
      if (st != 0) begin
        mPhase = "commit";
        mScore1 = 0; mScore2 = 0; mRound = 0;
      end
    end else if (mPhase == "commit") begin
      if (p1v != 0) begin
        mTarget = mapTarget(p1c);
        mTries  = TRIES;
        if (p1c == 0 || p1c == (1 << W) - 1) winRound(1);
        else mPhase = "guess";
      end
    end else if (mPhase == "guess") begin
      if (p2v != 0) begin
        if (p2c == mTarget) begin
          winRound(2);
        end else begin
          mTries--;
          mDica = (p2c < mTarget) ? 1 : 2;
          if (mTries == 0) winRound(1);
        end
      end
    end else if (mPhase == "result") begin
      mPhase = (mRound == ROUNDS) ? "over" : "commit";
    end
  endfunction

  task automatic compareAll();
    int expWinner = 0;
    if (mPhase == "over") begin
      if (mScore1 > mScore2)      expWinner = 1;
      else if (mScore2 > mScore1) expWinner = 2;
      else                        expWinner = 3;
    end
    checkOutput("s1", int'(s1), mS1);
    checkOutput("s2", int'(s2), mS2);
    checkOutput("score1", int'(score1), mScore1);
    checkOutput("score2", int'(score2), mScore2);
    checkOutput("round", int'(round), mRound);
    checkOutput("tries_left", int'(tries_left), mTries);
    checkOutput("busy", int'(busy),
                (mPhase == "commit" || mPhase == "guess" || mPhase == "result") ? 1 : 0);
    checkOutput("game_over", int'(game_over), (mPhase == "over") ? 1 : 0);
    checkOutput("winner", int'(winner), expWinner);
`ifdef BATALHA_DICA_EN
    checkOutput("dica", int'(dica), mDica);
`endif
  endtask

  // Drives one cycle of inputs (called while clk is low), runs the model,
  // lets the edge happen and compares every output shortly after it.
  task automatic applyStimulus(input int rn, input int st, input int p1v, input int p1c,
                               input int p2v, input int p2c);
    rst_n    = (rn != 0);
    start    = (st != 0);
    p1_valid = (p1v != 0);
    p1_code  = 3'(p1c);
    p2_valid = (p2v != 0);
    p2_code  = 3'(p2c);
    modelStep(rn, st, p1v, p1c, p2v, p2c);
    @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    p1_code = '0; p2_code = '0;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 3, 1, 3);

    // Round 1: code 001 maps to target 001; an immediate hit wins for p2.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 1, 1);
    checkOutput("t1_tries", int'(tries_left), 3);
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("t1_s2", int'(s2), 1);
    checkOutput("t1_score2", int'(score2), 1);
    checkOutput("t1_round", int'(round), 1);
    idleCycle();

    // Round 2: uniform code 111 wins for p1 with no guessing; the p2 strobe
    // in COMMIT is ignored.
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 7, 1, 7);
    checkOutput("t2_s1", int'(s1), 1);
    checkOutput("t2_score1", int'(score1), 1);
    idleCycle();

    // Round 3: code 011 maps to target 011. Three low guesses go to p1, with
    // a mid-game start and a stray p1 commit mixed in.
    applyStimulus(1, 0, 1, 3, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 7, 1, 0);
    checkOutput("t3_tries2", int'(tries_left), 2);
    applyStimulus(1, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 2);
    checkOutput("t3_tries0", int'(tries_left), 0);
    checkOutput("t3_s1", int'(s1), 1);
    idleCycle();

    // Round 4: code 010 maps to target 111; a p2 hit.
    applyStimulus(1, 0, 1, 2, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 7);
    idleCycle();

    // Round 5: uniform 000 wins for p1. The final score is 3-2, so p1 is the winner.
    applyStimulus(1, 0, 1, 0, 0, 0);
    idleCycle();
    checkOutput("t4_over", int'(game_over), 1);
    checkOutput("t4_winner", int'(winner), 1);
    checkOutput("t4_busy", int'(busy), 0);
    applyStimulus(1, 0, 1, 5, 1, 5);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("t4_clear", int'(score1) + int'(round), 0);

    // Reset during GUESS with score1 = 2. A low pulse between edges is ignored first.
    applyStimulus(1, 0, 1, 7, 0, 0);
    idleCycle();
    applyStimulus(1, 0, 1, 0, 0, 0);
    idleCycle();
    applyStimulus(1, 0, 1, 1, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t6_score1", int'(score1), 2);
    applyStimulus(0, 0, 0, 0, 1, 6);
    checkOutput("t6_busy", int'(busy), 0);

    // Random play with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0) ? 0 : 1,
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    ($urandom_range(0, 2) == 0) ? 1 : 0,
                    int'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 0) ? 1 : 0,
                    int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
